// File: rtl/div_pkg.sv
// Shared types and constants for the divider job controller.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    // Quotient reported for a zero divisor; replicate bit 0 for other widths.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUO = '1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/div_wait_timer.sv
// Cycle counter for the divider wait phase; flags the last permitted cycle.
module div_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign limit_hit = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/div_job_ctrl.sv
// Sequences operand pairs into an external sequential divider and holds each
// result (or a locally generated divide-by-zero / timeout result) for handoff.
module div_job_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_rst,
    input  logic [WIDTH-1:0] div_quo,
    input  logic [WIDTH-1:0] div_rem,
    input  logic             div_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic             out_timeout
);

    state_t state, state_next;
    logic   accept;
    logic   in_zero;
    logic   limit_hit;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign in_zero   = (in_b == '0);
    assign out_valid = (state == HOLD);

    div_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == START),
        .enable   (state == WAIT),
        .limit_hit(limit_hit)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = in_zero ? HOLD : START;
            START: state_next = WAIT;
            WAIT:  if (div_done || limit_hit) state_next = HOLD;
            HOLD:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // div_rst is registered from the next state so it is low exactly in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            div_rst     <= 1'b1;
            div_a       <= '0;
            div_b       <= '0;
            out_quo     <= '0;
            out_rem     <= '0;
            out_dbz     <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            state   <= state_next;
            div_rst <= (state_next != WAIT);
            if (accept) begin
                div_a       <= in_a;
                div_b       <= in_b;
                out_dbz     <= in_zero;
                out_timeout <= 1'b0;
                if (in_zero) begin
                    out_quo <= {WIDTH{DBZ_QUO[0]}};
                    out_rem <= in_a;
                end
            end
            if (state == WAIT) begin
                if (div_done) begin
                    out_quo <= div_quo;
                    out_rem <= div_rem;
                end else if (limit_hit) begin
                    out_quo     <= '0;
                    out_rem     <= '0;
                    out_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_job_ctrl.sv
// Directed bench for div_job_ctrl with a behavioural divider of programmable latency.
module tb_div_job_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [7:0] div_a, div_b;
    logic       div_rst;
    logic [7:0] div_quo, div_rem;
    logic       div_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quo, out_rem;
    logic       out_dbz, out_timeout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int unsigned lat  = 9;
    bit          hang = 1'b0;
    int unsigned dcnt;

    always #5 clk = ~clk;

    div_job_ctrl #(
        .WIDTH  (8),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_rst    (div_rst),
        .div_quo    (div_quo),
        .div_rem    (div_rem),
        .div_done   (div_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_quo    (out_quo),
        .out_rem    (out_rem),
        .out_dbz    (out_dbz),
        .out_timeout(out_timeout)
    );

    // Divider stand-in: done in the lat-th cycle after its reset is released.
    always @(posedge clk) begin
        if (div_rst) dcnt <= 0;
        else         dcnt <= dcnt + 1;
    end
    assign div_done = !div_rst && !hang && (dcnt == lat - 1);
    assign div_quo  = (div_b != 0) ? div_a / div_b : 8'hFF;
    assign div_rem  = (div_b != 0) ? div_a % div_b : div_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the accepting edge (state START/HOLD).
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        bit done_ok = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done_ok; i++) begin
            if (in_ready) done_ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done_ok) check("accept_bound", 0, 1);
    endtask

    task automatic wait_result(input int unsigned maxc, output int unsigned cyc);
        cyc = 0;
        while (!out_valid && cyc < maxc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) check("result_bound", 0, 1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_valid", out_valid, 0);
        check("handoff_ready", in_ready, 1);
    endtask

    // ecyc: edges from the START cycle to the first out_valid cycle.
    task automatic do_job(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input bit eto, input int unsigned ecyc);
        int unsigned cyc;
        send(a, b);
        check("start_div_rst", div_rst, 1);
        check("start_valid", out_valid, 0);
        check("start_div_a", div_a, a);
        check("start_div_b", div_b, b);
        @(posedge clk);
        #1;
        check("wait_div_rst", div_rst, 0);
        wait_result(40, cyc);
        check("latency", cyc + 1, ecyc);
        check("quo", out_quo, eq);
        check("rem", out_rem, er);
        check("dbz", out_dbz, 0);
        check("timeout", out_timeout, eto);
        check("hold_div_rst", div_rst, 1);
        handoff();
    endtask

    initial begin
        int unsigned cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // reset
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_in_ready", in_ready, 0);
            check("rst_div_rst", div_rst, 1);
            check("rst_valid", out_valid, 0);
            check("rst_quo", out_quo, 0);
            check("rst_rem", out_rem, 0);
        end
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_div_rst", div_rst, 1);

        // basic jobs through the divider model
        do_job(8'd7,  8'd2, 8'd3, 8'd1, 1'b0, 10);
        do_job(8'd15, 8'd3, 8'd5, 8'd0, 1'b0, 10);
        do_job(8'd63, 8'd8, 8'd7, 8'd7, 1'b0, 10);
        do_job(8'd32, 8'd8, 8'd4, 8'd0, 1'b0, 10);

        // backpressure: result held, new operands ignored
        send(8'd255, 8'd9);
        wait_result(40, cyc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 8'd1;
            in_b     = 8'd1;
            check("bp_valid", out_valid, 1);
            check("bp_quo", out_quo, 28);
            check("bp_rem", out_rem, 3);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_div_a", div_a, 255);
        handoff();

        // divide by zero: immediate result, divider stays in reset
        send(8'h3F, 8'h00);
        check("dbz_valid", out_valid, 1);
        check("dbz_quo", out_quo, 8'hFF);
        check("dbz_rem", out_rem, 8'h3F);
        check("dbz_flag", out_dbz, 1);
        check("dbz_to", out_timeout, 0);
        for (int i = 0; i < 3; i++) begin
            check("dbz_div_rst", div_rst, 1);
            @(posedge clk);
            #1;
        end
        check("dbz_div_rst_end", div_rst, 1);
        handoff();

        // timeout: divider never finishes
        hang = 1'b1;
        do_job(8'd9, 8'd3, 8'd0, 8'd0, 1'b1, 17);
        hang = 1'b0;

        // done on the limit cycle wins over timeout
        lat = 16;
        do_job(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 17);
        lat = 9;

        // reset three cycles into WAIT
        send(8'd255, 8'd9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_wait_div_rst", div_rst, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_div_rst", div_rst, 1);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_div_a", div_a, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        do_job(8'd32, 8'd8, 8'd4, 8'd0, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
